// File: rtl/mac_bank_pkg.sv
// Shared widths and saturation helper for the MAC bank and its post-processing stage.
package mac_bank_pkg;

  localparam int N_LANE_DEF    = 12;
  localparam int N_ELEM_DEF    = 16;
  localparam int DATA_W_DEF    = 8;
  localparam int ACC_W_DEF     = 24;
  localparam int OUT_W_DEF     = 20;
  localparam int MAX_BEATS_DEF = 256;

  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats);
  endfunction

  // Clamp a signed value into the range of a signed 'width'-bit number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: product stage, sum stage, saturating accumulator and
// shifted/saturated/ReLU output register with a per-group overflow flag.
module mac_lane
  import mac_bank_pkg::*;
#(
  parameter int N_ELEM = N_ELEM_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     s2_vld,
  input  logic                     s2_first,
  input  logic [4:0]               s3_shift,
  input  logic                     s3_relu,
  input  logic                     load,
  input  logic [N_ELEM*DATA_W-1:0] din,
  input  logic [N_ELEM*DATA_W-1:0] weight,
  output logic [OUT_W-1:0]         result,
  output logic                     grp_ovf
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + $clog2(N_ELEM);

  logic signed [PROD_W-1:0] prod_reg [N_ELEM];
  logic signed [SUM_W-1:0]  sum_next;
  logic signed [SUM_W-1:0]  sum_reg;
  logic signed [ACC_W-1:0]  acc_reg;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W:0]    acc_wide;
  logic signed [63:0]       acc_sat;
  logic                     acc_clamp;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [63:0]       out_sat;
  logic                     out_clamp;
  logic signed [OUT_W-1:0]  out_val;
  logic                     ovf_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_ELEM; gi++) begin : g_prod
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prod_reg[gi] <= '0;
        end else if (en) begin
          prod_reg[gi] <= PROD_W'($signed(din[gi*DATA_W +: DATA_W]))
                        * PROD_W'($signed(weight[gi*DATA_W +: DATA_W]));
        end
      end
    end
  endgenerate

  always_comb begin
    sum_next = '0;
    for (int e = 0; e < N_ELEM; e++) begin
      sum_next = sum_next + SUM_W'(prod_reg[e]);
    end
  end

  // The first beat of a group overwrites the accumulator instead of adding.
  always_comb begin
    acc_wide  = (ACC_W+1)'(acc_reg) + (ACC_W+1)'(sum_reg);
    acc_sat   = sat_signed(64'(acc_wide), ACC_W);
    acc_clamp = 1'b0;
    acc_next  = ACC_W'(acc_sat);
    if (s2_first) begin
      acc_next = ACC_W'(sum_reg);
    end else begin
      acc_clamp = (acc_sat != 64'(acc_wide));
    end
  end

  // ReLU is applied after the clamp so it never contributes to the overflow flag.
  always_comb begin
    shifted   = acc_reg >>> s3_shift;
    out_sat   = sat_signed(64'(shifted), OUT_W);
    out_clamp = (out_sat != 64'(shifted));
    out_val   = OUT_W'(out_sat);
    if (s3_relu && out_val[OUT_W-1]) begin
      out_val = '0;
    end
  end

  assign grp_ovf = ovf_reg | out_clamp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg <= '0;
      acc_reg <= '0;
      ovf_reg <= 1'b0;
      result  <= '0;
    end else begin
      if (en) begin
        sum_reg <= sum_next;
      end
      if (en && s2_vld) begin
        acc_reg <= acc_next;
        ovf_reg <= (s2_first ? 1'b0 : ovf_reg) | acc_clamp;
      end
      if (load) begin
        result <= out_val;
      end
    end
  end

endmodule

// File: rtl/mac_bank_acc.sv
// Bank of MAC lanes with group beat counter, per-group config latch,
// pipeline tags and a stalling valid/ready output register.
module mac_bank_acc
  import mac_bank_pkg::*;
#(
  parameter int  N_LANE    = N_LANE_DEF,
  parameter int  N_ELEM    = N_ELEM_DEF,
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  ACC_W     = ACC_W_DEF,
  parameter int  OUT_W     = OUT_W_DEF,
  parameter int  MAX_BEATS = MAX_BEATS_DEF,
  localparam int CNT_W     = cnt_width(MAX_BEATS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CNT_W-1:0]                cfg_beats,
  input  logic [4:0]                      cfg_shift,
  input  logic                            cfg_relu,
  input  logic                            vld_i,
  output logic                            rdy_o,
  input  logic [N_LANE*N_ELEM*DATA_W-1:0] iDin,
  input  logic [N_LANE*N_ELEM*DATA_W-1:0] iWeight,
  output logic [N_LANE*OUT_W-1:0]         oOut,
  output logic                            vld_o,
  input  logic                            rdy_i,
  output logic                            ovf_o,
  output logic [CNT_W-1:0]                beat_cnt_o
);

  localparam int LANE_W = N_ELEM * DATA_W;

  logic             en;
  logic             accept;
  logic             first;
  logic             last;
  logic             load;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] beats_reg;
  logic [4:0]       shift_reg;
  logic             relu_reg;
  logic [CNT_W-1:0] beats_cur;
  logic [4:0]       shift_cur;
  logic             relu_cur;
  logic             s1_vld, s1_first, s1_last, s1_relu;
  logic             s2_vld, s2_first, s2_last, s2_relu;
  logic             s3_vld, s3_last, s3_relu;
  logic [4:0]       s1_shift, s2_shift, s3_shift;
  logic [N_LANE-1:0] lane_ovf;

  assign en         = !(vld_o && !rdy_i);
  assign rdy_o      = en;
  assign accept     = vld_i && en;
  assign first      = (cnt_reg == '0);
  assign beats_cur  = first ? cfg_beats : beats_reg;
  assign shift_cur  = first ? cfg_shift : shift_reg;
  assign relu_cur   = first ? cfg_relu  : relu_reg;
  assign last       = (cnt_reg == beats_cur);
  assign load       = en && s3_vld && s3_last;
  assign beat_cnt_o = cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      beats_reg <= '0;
      shift_reg <= '0;
      relu_reg  <= 1'b0;
    end else if (accept) begin
      beats_reg <= beats_cur;
      shift_reg <= shift_cur;
      relu_reg  <= relu_cur;
      cnt_reg   <= last ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  // shift/relu ride with each beat so one-beat groups can change config every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1_vld, s1_first, s1_last, s1_relu, s1_shift} <= '0;
      {s2_vld, s2_first, s2_last, s2_relu, s2_shift} <= '0;
      {s3_vld, s3_last, s3_relu, s3_shift}           <= '0;
    end else if (en) begin
      {s1_vld, s1_first, s1_last, s1_relu, s1_shift} <= {accept, first, last, relu_cur, shift_cur};
      {s2_vld, s2_first, s2_last, s2_relu, s2_shift} <= {s1_vld, s1_first, s1_last, s1_relu, s1_shift};
      {s3_vld, s3_last, s3_relu, s3_shift}           <= {s2_vld, s2_last, s2_relu, s2_shift};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_o <= 1'b0;
      ovf_o <= 1'b0;
    end else if (load) begin
      vld_o <= 1'b1;
      ovf_o <= |lane_ovf;
    end else if (rdy_i) begin
      vld_o <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LANE; gi++) begin : g_lane
      mac_lane #(
        .N_ELEM (N_ELEM),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .s2_vld   (s2_vld),
        .s2_first (s2_first),
        .s3_shift (s3_shift),
        .s3_relu  (s3_relu),
        .load     (load),
        .din      (iDin[gi*LANE_W +: LANE_W]),
        .weight   (iWeight[gi*LANE_W +: LANE_W]),
        .result   (oOut[gi*OUT_W +: OUT_W]),
        .grp_ovf  (lane_ovf[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_mac_bank_acc.sv
// Scoreboard bench for mac_bank_acc: a reference model queues each group
// result when its last beat is accepted; a monitor pops it on consumption.
`timescale 1ns/1ps
module tb_mac_bank_acc;

  localparam int N_LANE = 12;
  localparam int N_ELEM = 16;
  localparam int DATA_W = 8;
  localparam int OUT_W  = 20;
  localparam int CNT_W  = 8;
  localparam int VEC_W  = N_LANE * N_ELEM * DATA_W;
  localparam int OV_W   = N_LANE * OUT_W;
  localparam longint ACC_MAX = 64'sd8388607;
  localparam longint ACC_MIN = -64'sd8388608;
  localparam longint OUT_MAX = 64'sd524287;
  localparam longint OUT_MIN = -64'sd524288;

  typedef struct packed {
    logic [OV_W-1:0] out;
    logic            ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] cfg_beats;
  logic [4:0]       cfg_shift;
  logic             cfg_relu;
  logic             vld_i;
  logic             rdy_o;
  logic [VEC_W-1:0] iDin;
  logic [VEC_W-1:0] iWeight;
  logic [OV_W-1:0]  oOut;
  logic             vld_o;
  logic             rdy_i;
  logic             ovf_o;
  logic [CNT_W-1:0] beat_cnt_o;

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   exp_q[$];
  exp_t   mon_e;
  longint m_acc [N_LANE];
  int     m_cnt = 0;
  int     m_beats = 0;
  int     m_shift = 0;
  bit     m_relu = 0;
  bit     m_ovf = 0;

  mac_bank_acc dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_beats  (cfg_beats),
    .cfg_shift  (cfg_shift),
    .cfg_relu   (cfg_relu),
    .vld_i      (vld_i),
    .rdy_o      (rdy_o),
    .iDin       (iDin),
    .iWeight    (iWeight),
    .oOut       (oOut),
    .vld_o      (vld_o),
    .rdy_i      (rdy_i),
    .ovf_o      (ovf_o),
    .beat_cnt_o (beat_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] splat(input int v);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < N_LANE * N_ELEM; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v);
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] gen_vec(input int k, input int sel);
    logic [VEC_W-1:0] r;
    for (int l = 0; l < N_LANE; l++)
      for (int e = 0; e < N_ELEM; e++)
        r[(l*N_ELEM+e)*DATA_W +: DATA_W] = DATA_W'(((l*13 + e*(7+sel) + k*29 + sel*5) % 256) - 128);
    return r;
  endfunction

  function automatic logic [OV_W-1:0] lanes_const(input int v);
    logic [OV_W-1:0] r;
    for (int l = 0; l < N_LANE; l++) r[l*OUT_W +: OUT_W] = OUT_W'(v);
    return r;
  endfunction

  task automatic model_beat(input logic [VEC_W-1:0] d, input logic [VEC_W-1:0] w,
                            input int beats, input int shift, input bit relu);
    longint s, t, r;
    logic [OV_W-1:0] vec;
    exp_t e;
    bit first;
    first = (m_cnt == 0);
    if (first) begin
      m_beats = beats; m_shift = shift; m_relu = relu; m_ovf = 0;
    end
    for (int l = 0; l < N_LANE; l++) begin
      s = 0;
      for (int k = 0; k < N_ELEM; k++)
        s += longint'($signed(d[(l*N_ELEM+k)*DATA_W +: DATA_W])) *
             longint'($signed(w[(l*N_ELEM+k)*DATA_W +: DATA_W]));
      if (first) m_acc[l] = s;
      else begin
        t = m_acc[l] + s;
        if (t > ACC_MAX) begin t = ACC_MAX; m_ovf = 1; end
        else if (t < ACC_MIN) begin t = ACC_MIN; m_ovf = 1; end
        m_acc[l] = t;
      end
    end
    if (m_cnt == m_beats) begin
      vec = '0;
      for (int l = 0; l < N_LANE; l++) begin
        r = m_acc[l] >>> m_shift;
        if (r > OUT_MAX) begin r = OUT_MAX; m_ovf = 1; end
        else if (r < OUT_MIN) begin r = OUT_MIN; m_ovf = 1; end
        if (m_relu && r < 0) r = 0;
        vec[l*OUT_W +: OUT_W] = r[OUT_W-1:0];
      end
      e.out = vec;
      e.ovf = m_ovf;
      exp_q.push_back(e);
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
  task automatic send_beat(input logic [VEC_W-1:0] d, input logic [VEC_W-1:0] w,
                           input int beats, input int shift, input bit relu);
    bit done;
    done = 0;
    iDin = d; iWeight = w; vld_i = 1'b1;
    cfg_beats = CNT_W'(beats); cfg_shift = 5'(shift); cfg_relu = relu;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      done = rdy_o;
      @(posedge clk); #1;
    end
    if (done) model_beat(d, w, beats, shift, relu);
    else check_val("send_timeout", 256'(rdy_o), 256'(1));
  endtask

  task automatic idle(input int n);
    vld_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    vld_i = 1'b0;
    for (int c = 0; c < 100 && (exp_q.size() != 0 || vld_o); c++) begin
      @(posedge clk); #1;
    end
    check_val("drain", 256'(exp_q.size()), 256'(0));
  endtask

  always @(negedge clk) begin
    if (!rst && vld_o && rdy_i) begin
      if (exp_q.size() == 0) begin
        check_val("sb_underflow", 256'(vld_o), 256'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check_val("sb_out", 256'(oOut), 256'(mon_e.out));
        check_val("sb_ovf", 256'(ovf_o), 256'(mon_e.ovf));
        $display("result popped: ovf=%0b lane0=%0d", ovf_o, $signed(oOut[OUT_W-1:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int run, max_run;
    rst = 1'b1; vld_i = 1'b0; rdy_i = 1'b1;
    cfg_beats = '0; cfg_shift = '0; cfg_relu = 1'b0;
    iDin = '0; iWeight = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("rst_vld", 256'(vld_o), 256'(0));
    check_val("rst_out", 256'(oOut), 256'(0));
    check_val("rst_ovf", 256'(ovf_o), 256'(0));
    check_val("rst_cnt", 256'(beat_cnt_o), 256'(0));
    check_val("rst_rdy", 256'(rdy_o), 256'(1));

    // 1: basic 4-beat group and latency
    for (int b = 0; b < 4; b++) begin
      send_beat(splat(1), splat(2), 3, 0, 0);
      if (b == 1) check_val("t1_cnt", 256'(beat_cnt_o), 256'(2));
    end
    vld_i = 1'b0;
    check_val("t1_wrap", 256'(beat_cnt_o), 256'(0));
    check_val("t1_lat0", 256'(vld_o), 256'(0));
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check_val("t1_lat", 256'(vld_o), 256'(k == 3));
    end
    check_val("t1_value", 256'(oOut), 256'(lanes_const(128)));
    drain();

    // 2: back-pressure with a second group pending
    rdy_i = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(splat(1), splat(2), 3, 0, 0);
    fork
      begin
        for (int b = 0; b < 4; b++) begin
          send_beat(splat(2), splat(3), 3, 1, 0);
          if (b == 1) idle(1);
        end
        vld_i = 1'b0;
      end
      begin
        for (int c = 0; c < 20 && !vld_o; c++) @(negedge clk);
        check_val("t2_vld", 256'(vld_o), 256'(1));
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check_val("t2_rdy", 256'(rdy_o), 256'(0));
          check_val("t2_hold", 256'(oOut), 256'(lanes_const(128)));
        end
        @(posedge clk); #1 rdy_i = 1'b1;
      end
    join
    drain();

    // 3: accumulator saturation; cfg changes mid-group must be ignored
    for (int b = 0; b < 33; b++) begin
      if (b == 0) send_beat(splat(127), splat(127), 32, 4, 0);
      else        send_beat(splat(127), splat(127), 5, 0, 1);
    end
    drain();

    // 4: single-beat groups, negative result with and without ReLU
    send_beat(splat(-1), splat(1), 0, 0, 0);
    send_beat(splat(-1), splat(1), 0, 0, 1);
    drain();

    // 5: reset mid-group discards the partial group
    send_beat(splat(1), splat(2), 3, 0, 0);
    send_beat(splat(1), splat(2), 3, 0, 0);
    check_val("t5_cnt2", 256'(beat_cnt_o), 256'(2));
    vld_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    m_cnt = 0;
    check_val("t5_cnt0", 256'(beat_cnt_o), 256'(0));
    check_val("t5_rdy", 256'(rdy_o), 256'(1));
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check_val("t5_novld", 256'(vld_o), 256'(0));
    end
    for (int b = 0; b < 4; b++) begin
      send_beat(splat(1), splat(2), 3, 0, 0);
      if (b == 0) check_val("t5_cnt1", 256'(beat_cnt_o), 256'(1));
    end
    drain();

    // 6: one-beat groups at full throughput
    run = 0; max_run = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) send_beat(gen_vec(k, 0), gen_vec(k, 1), 0, 2, 0);
        vld_i = 1'b0;
      end
      begin
        for (int c = 0; c < 25; c++) begin
          @(negedge clk);
          run = vld_o ? run + 1 : 0;
          if (run > max_run) max_run = run;
        end
      end
    join
    check_val("t6_run", 256'(max_run), 256'(10));
    drain();

    check_val("sb_empty", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
